// File: rtl/xbus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xbus_arb_pkg
// Purpose : Shared widths and FSM state encodings for the xbus arbiter slice.
//           DATA_W / INT_ADDR_W size the rw bus; xarb_state_e holds the 2-bit
//           arbiter states (IDLE, grant to master 0, grant to master 1).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package xbus_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int INT_ADDR_W = 8;

  typedef enum logic [1:0] {
    XARB_IDLE = 2'd0,
    XARB_GNT0 = 2'd1,
    XARB_GNT1 = 2'd2
  } xarb_state_e;

endpackage : xbus_arb_pkg
`default_nettype wire

// File: rtl/xbus_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : xbus_arb_if
// Purpose : Bundles both master request channels and the slave channel of the
//           xbus arbiter.
//           modport master : requester/memory side (drives m*_req fields and
//                            s_rdata/s_ready, observes acks and s_* fields)
//           modport slave  : arbiter side (opposite directions)
// Ports   : m0_req/rnw/addr/wdata -> arb, m0_rdata/ack/err <- arb
//           m1_* identical, s_req/rnw/addr/wdata <- arb, s_rdata/ready -> arb
// Rev     : 1.0  initial release
// ============================================================================
interface xbus_arb_if;
  import xbus_arb_pkg::*;

  logic                  m0_req;
  logic                  m0_rnw;
  logic [INT_ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [DATA_W-1:0]     m0_rdata;
  logic                  m0_ack;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_rnw;
  logic [INT_ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [DATA_W-1:0]     m1_rdata;
  logic                  m1_ack;
  logic                  m1_err;

  logic                  s_req;
  logic                  s_rnw;
  logic [INT_ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic [DATA_W-1:0]     s_rdata;
  logic                  s_ready;

  modport master (
    output m0_req, m0_rnw, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_rnw, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  s_req, s_rnw, s_addr, s_wdata,
    output s_rdata, s_ready
  );

  modport slave (
    input  m0_req, m0_rnw, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_rnw, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output s_req, s_rnw, s_addr, s_wdata,
    input  s_rdata, s_ready
  );

endinterface : xbus_arb_if
`default_nettype wire

// File: rtl/xbus_arb_timer.sv
`default_nettype none
// ============================================================================
// Module  : xarb_timer
// Purpose : Timeout counter for the xbus arbiter. Counts up while i_cnt is
//           high, returns to zero on i_clr, and flags o_expire in the cycle
//           whose counting edge would make the count reach TIMEOUT.
// Ports   : clk, rst (async, active-high)
//           i_clr    clear the count (priority over i_cnt)
//           i_cnt    count this cycle
//           o_expire TIMEOUT-th counted cycle (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module xarb_timer #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_cnt,
  output logic      o_expire
);

  localparam logic [TO_W-1:0] c_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire is flagged one edge early so the abort lands on the same edge
  // the count reaches TIMEOUT.
  assign o_expire = i_cnt && (r_cnt == c_LAST);

endmodule : xarb_timer
`default_nettype wire

// File: rtl/xbus_arb.sv
`default_nettype none
// ============================================================================
// Module  : xbus_arb
// Purpose : Two-master arbiter for the internal rw bus. Master 0 is xctrl,
//           master 1 is the PS2 scancode writer; a single registered slave
//           port feeds the memory/peripheral decoder. Ties are resolved
//           round-robin; a watchdog aborts a transfer whose slave keeps
//           s_ready low for TIMEOUT cycles (ack + err, rdata forced to 0).
// Config  : XBUS_ARB_FIXED_PRIO_EN defined -> master 0 always wins ties.
// Ports   : clk  system clock, rising edge
//           rst  asynchronous, active-high reset
//           bus  xbus_arb_if.slave (m0_*, m1_* request channels, s_* port)
// Params  : TIMEOUT  s_ready-low cycles allowed per transfer (>=1)
//           TO_W     timeout counter width (2**TO_W > TIMEOUT)
// Rev     : 1.0  initial release
// ============================================================================
module xbus_arb
  import xbus_arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input wire logic  clk,
  input wire logic  rst,
  xbus_arb_if.slave bus
);

  xarb_state_e           r_state;
  xarb_state_e           w_next_state;

  logic                  r_s_req;
  logic                  r_s_rnw;
  logic [INT_ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0]     r_s_wdata;

  logic                  r_m0_ack;
  logic                  r_m0_err;
  logic [DATA_W-1:0]     r_m0_rdata;
  logic                  r_m1_ack;
  logic                  r_m1_err;
  logic [DATA_W-1:0]     r_m1_rdata;

  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_finish;
  logic                  w_abort;
  logic                  w_in_gnt;
  logic                  w_tcnt;
  logic                  w_tclr;
  logic                  w_expire;

`ifndef XBUS_ARB_FIXED_PRIO_EN
  // Index of the master served last; 1 after reset so master 0 wins the
  // first tie.
  logic                  r_last;
`endif

  // A master whose ack is showing this cycle still has its stale req up.
  assign w_elig0  = bus.m0_req && !r_m0_ack;
  assign w_elig1  = bus.m1_req && !r_m1_ack;
  assign w_in_gnt = (r_state == XARB_GNT0) || (r_state == XARB_GNT1);

  assign w_tcnt = w_in_gnt && !bus.s_ready;
  assign w_tclr = !w_in_gnt || bus.s_ready || w_expire;

  xarb_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tclr),
    .i_cnt    (w_tcnt),
    .o_expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= XARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and grant/complete decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      XARB_IDLE: begin
        if (w_elig0 && w_elig1) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
          w_grant0 = 1'b1;
`else
          w_grant0 = r_last;
          w_grant1 = !r_last;
`endif
        end else begin
          w_grant0 = w_elig0;
          w_grant1 = w_elig1;
        end
        if (w_grant0) begin
          w_next_state = XARB_GNT0;
        end else if (w_grant1) begin
          w_next_state = XARB_GNT1;
        end
      end
      XARB_GNT0, XARB_GNT1: begin
        if (bus.s_ready) begin
          w_finish     = 1'b1;
          w_next_state = XARB_IDLE;
        end else if (w_expire) begin
          w_abort      = 1'b1;
          w_next_state = XARB_IDLE;
        end
      end
      default: begin
        w_next_state = XARB_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slave port and master response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_req    <= 1'b0;
      r_s_rnw    <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;

      if (w_grant0) begin
        r_s_req   <= 1'b1;
        r_s_rnw   <= bus.m0_rnw;
        r_s_addr  <= bus.m0_addr;
        r_s_wdata <= bus.m0_wdata;
      end else if (w_grant1) begin
        r_s_req   <= 1'b1;
        r_s_rnw   <= bus.m1_rnw;
        r_s_addr  <= bus.m1_addr;
        r_s_wdata <= bus.m1_wdata;
      end

      // s_* fields are left holding the last transfer after s_req drops.
      if (w_finish || w_abort) begin
        r_s_req <= 1'b0;
      end

      if (w_finish) begin
        if (r_state == XARB_GNT0) begin
          r_m0_ack <= 1'b1;
          if (r_s_rnw) begin
            r_m0_rdata <= bus.s_rdata;
          end
        end else begin
          r_m1_ack <= 1'b1;
          if (r_s_rnw) begin
            r_m1_rdata <= bus.s_rdata;
          end
        end
      end

      if (w_abort) begin
        if (r_state == XARB_GNT0) begin
          r_m0_ack   <= 1'b1;
          r_m0_err   <= 1'b1;
          r_m0_rdata <= '0;
        end else begin
          r_m1_ack   <= 1'b1;
          r_m1_err   <= 1'b1;
          r_m1_rdata <= '0;
        end
      end
    end
  end

`ifndef XBUS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_grant0) begin
      r_last <= 1'b0;
    end else if (w_grant1) begin
      r_last <= 1'b1;
    end
  end
`endif

  assign bus.s_req    = r_s_req;
  assign bus.s_rnw    = r_s_rnw;
  assign bus.s_addr   = r_s_addr;
  assign bus.s_wdata  = r_s_wdata;
  assign bus.m0_ack   = r_m0_ack;
  assign bus.m0_err   = r_m0_err;
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m1_ack   = r_m1_ack;
  assign bus.m1_err   = r_m1_err;
  assign bus.m1_rdata = r_m1_rdata;

endmodule : xbus_arb
`default_nettype wire
